// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between a sweep host (master) and dds_sweep_ctrl (slave).
interface dds_sweep_ctrl_if #(
  parameter int DWELL_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic                   stop;
  logic                   continuous;
  logic [15:0]            start_inc;
  logic [15:0]            stop_inc;
  logic [15:0]            step_inc;
  logic [DWELL_WIDTH-1:0] dwell_cycles;
  logic [15:0]            dds_phase_inc;
  logic                   dds_enable;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] sweep_count;

  modport master (
    output start, stop, continuous, start_inc, stop_inc, step_inc, dwell_cycles,
    input  dds_phase_inc, dds_enable, busy, done, sweep_count
  );

  modport slave (
    input  start, stop, continuous, start_inc, stop_inc, step_inc, dwell_cycles,
    output dds_phase_inc, dds_enable, busy, done, sweep_count
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear phase-increment sweep generator feeding a DDS; sawtooth by default,
// up-then-down triangle when DDS_SWEEP_TRIANGLE_EN is defined.
module dds_sweep_ctrl #(
  parameter int DWELL_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  dds_sweep_ctrl_if.slave   bus
);

`ifdef DDS_SWEEP_TRIANGLE_EN
  typedef enum logic [1:0] {IDLE, RAMP, RAMP_BACK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RAMP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [15:0]            cur_q, cur_d;
  logic [15:0]            start_q, start_d;
  logic [15:0]            stop_q, stop_d;
  logic [15:0]            step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   up_q, up_d;
  logic                   run_q, run_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   sweep_end;
  logic [DWELL_WIDTH-1:0] dwell_eff;

  // One step toward target in 17-bit arithmetic; overshoot, overflow or underflow clamps.
  function automatic logic [15:0] step_toward(input logic [15:0] cur, input logic [15:0] step,
                                              input logic [15:0] target, input logic up);
    logic [16:0] res;
    logic        clamp;
    if (up) begin
      res   = {1'b0, cur} + {1'b0, step};
      clamp = res[16] || (res[15:0] >= target);
    end else begin
      res   = {1'b0, cur} - {1'b0, step};
      clamp = res[16] || (res[15:0] <= target);
    end
    return clamp ? target : res[15:0];
  endfunction

  assign dwell_eff = (bus.dwell_cycles == '0) ? DWELL_WIDTH'(1) : bus.dwell_cycles;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    start_d   = start_q;
    stop_d    = stop_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    up_d      = up_q;
    run_d     = run_q;
    done_d    = 1'b0;
    count_d   = count_q;
    sweep_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RAMP;
          cur_d   = bus.start_inc;
          start_d = bus.start_inc;
          stop_d  = bus.stop_inc;
          step_d  = bus.step_inc;
          dwell_d = dwell_eff;
          cnt_d   = dwell_eff - DWELL_WIDTH'(1);
          up_d    = (bus.start_inc <= bus.stop_inc);
          run_d   = 1'b1;
          count_d = '0;
        end
      end
      RAMP: begin
        if (bus.stop) begin
          state_d = IDLE;
          run_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else if (cur_q == stop_q || step_q == '0) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
          if (step_q == '0 || start_q == stop_q) begin
            sweep_end = 1'b1;
          end else begin
            state_d = RAMP_BACK;
            cur_d   = step_toward(cur_q, step_q, start_q, !up_q);
            cnt_d   = dwell_q - DWELL_WIDTH'(1);
          end
`else
          sweep_end = 1'b1;
`endif
        end else begin
          cur_d = step_toward(cur_q, step_q, stop_q, up_q);
          cnt_d = dwell_q - DWELL_WIDTH'(1);
        end
      end
`ifdef DDS_SWEEP_TRIANGLE_EN
      RAMP_BACK: begin
        if (bus.stop) begin
          state_d = IDLE;
          run_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else if (cur_q == start_q) begin
          sweep_end = 1'b1;
        end else begin
          cur_d = step_toward(cur_q, step_q, start_q, !up_q);
          cnt_d = dwell_q - DWELL_WIDTH'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        run_d   = 1'b0;
      end
    endcase

    // Continuous mode restarts with no gap cycle and suppresses done.
    if (sweep_end) begin
      count_d = count_q + COUNT_WIDTH'(1);
      if (bus.continuous) begin
        state_d = RAMP;
        cur_d   = start_q;
        cnt_d   = dwell_q - DWELL_WIDTH'(1);
      end else begin
        state_d = IDLE;
        run_d   = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      run_q   <= run_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign bus.dds_phase_inc = cur_q;
  assign bus.dds_enable    = run_q;
  assign bus.busy          = run_q;
  assign bus.done          = done_q;
  assign bus.sweep_count   = count_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized and directed checks of dds_sweep_ctrl against a value-list sweep model.
module tb_dds_sweep_ctrl;
  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   exp_q[$];
  int   cur_dw;

  dds_sweep_ctrl_if #(.DWELL_WIDTH(16), .COUNT_WIDTH(16)) bus ();

  dds_sweep_ctrl #(.DWELL_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sequence of increments a sweep should visit, from plain clamped arithmetic.
  task automatic build_list(input int s, input int e, input int st);
    int v;
    exp_q.delete();
    exp_q.push_back(s);
    if (st == 0 || s == e) return;
    v = s;
    while (v != e) begin
      if (s < e) v = (v + st > e) ? e : v + st;
      else       v = (v - st < e) ? e : v - st;
      exp_q.push_back(v);
    end
`ifdef DDS_SWEEP_TRIANGLE_EN
    while (v != s) begin
      if (s < e) v = (v - st < s) ? s : v - st;
      else       v = (v + st > s) ? s : v + st;
      exp_q.push_back(v);
    end
`endif
  endtask

  task automatic launch(input int si, input int so, input int st, input int dw, input bit cont);
    @(negedge clock);
    bus.start_inc    = 16'(si);
    bus.stop_inc     = 16'(so);
    bus.step_inc     = 16'(st);
    bus.dwell_cycles = 16'(dw);
    bus.continuous   = cont;
    bus.stop         = 1'b0;
    bus.start        = 1'b1;
    build_list(si, so, st);
    cur_dw = (dw == 0) ? 1 : dw;
  endtask

  // Every cycle of one sweep; data inputs are scrambled to show they are ignored while busy.
  task automatic check_sweep(input int sweep_idx);
    foreach (exp_q[i]) begin
      for (int d = 0; d < cur_dw; d++) begin
        @(posedge clock); #1;
        bus.start        = 1'b0;
        bus.start_inc    = 16'($urandom);
        bus.stop_inc     = 16'($urandom);
        bus.step_inc     = 16'($urandom);
        bus.dwell_cycles = 16'($urandom);
        $display("[TB] sweep %0d value %0d dwell %0d: inc=0x%0h exp=0x%0h", sweep_idx, i, d,
                 bus.dds_phase_inc, exp_q[i]);
        check_eq("phase_inc", 32'(bus.dds_phase_inc), 32'(exp_q[i]));
        check_eq("enable",    32'(bus.dds_enable), 32'd1);
        check_eq("busy",      32'(bus.busy), 32'd1);
        check_eq("done_mid",  32'(bus.done), 32'd0);
        check_eq("count_mid", 32'(bus.sweep_count), 32'(sweep_idx));
      end
    end
  endtask

  task automatic check_done(input int last);
    @(posedge clock); #1;
    $display("[TB] end of sweep: done=%0d busy=%0d count=%0d", bus.done, bus.busy, bus.sweep_count);
    check_eq("done_pulse", 32'(bus.done), 32'd1);
    check_eq("busy_end",   32'(bus.busy), 32'd0);
    check_eq("enable_end", 32'(bus.dds_enable), 32'd0);
    check_eq("count_end",  32'(bus.sweep_count), 32'd1);
    check_eq("phase_held", 32'(bus.dds_phase_inc), 32'(last));
    @(posedge clock); #1;
    check_eq("done_single", 32'(bus.done), 32'd0);
    check_eq("idle_busy",   32'(bus.busy), 32'd0);
  endtask

  task automatic single_sweep(input int si, input int so, input int st, input int dw);
    launch(si, so, st, dw, 1'b0);
    check_sweep(0);
    check_done(exp_q[exp_q.size()-1]);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_phase"},  32'(bus.dds_phase_inc), 32'd0);
    check_eq({tag, "_enable"}, 32'(bus.dds_enable), 32'd0);
    check_eq({tag, "_busy"},   32'(bus.busy), 32'd0);
    check_eq({tag, "_done"},   32'(bus.done), 32'd0);
    check_eq({tag, "_count"},  32'(bus.sweep_count), 32'd0);
  endtask

  initial begin
    int si, so, st, dw, diff;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0;
    bus.start_inc = '0; bus.stop_inc = '0; bus.step_inc = '0; bus.dwell_cycles = '0;
    #1;
    $display("[TB] reset state check");
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    single_sweep(16'h0100, 16'h0400, 16'h0100, 3);
    single_sweep(16'h1000, 16'h1050, 16'h0020, 1);
    single_sweep(16'hFFE0, 16'hFFFF, 16'h0010, 1);
    single_sweep(16'hFFF0, 16'hFFC0, 16'h0010, 2);
    single_sweep(16'h0100, 16'h0300, 16'h0100, 1);
    single_sweep(16'h0500, 16'h0500, 16'h0100, 2);
    single_sweep(16'h0100, 16'h0900, 16'h0000, 0);

    // Continuous: three wraps, then abort mid-dwell of the fourth sweep.
    launch(16'h0100, 16'h0400, 16'h0100, 3, 1'b1);
    for (int s = 0; s < 3; s++) check_sweep(s);
    @(posedge clock); #1;
    check_eq("cont_restart", 32'(bus.dds_phase_inc), 32'h0100);
    check_eq("cont_count3",  32'(bus.sweep_count), 32'd3);
    check_eq("cont_nodone",  32'(bus.done), 32'd0);
    bus.stop = 1'b1;
    @(posedge clock); #1;
    $display("[TB] stop: enable=%0d busy=%0d inc=0x%0h", bus.dds_enable, bus.busy, bus.dds_phase_inc);
    check_eq("stop_enable", 32'(bus.dds_enable), 32'd0);
    check_eq("stop_busy",   32'(bus.busy), 32'd0);
    check_eq("stop_done",   32'(bus.done), 32'd0);
    check_eq("stop_phase",  32'(bus.dds_phase_inc), 32'h0100);
    check_eq("stop_count",  32'(bus.sweep_count), 32'd3);
    bus.continuous = 1'b0;

    // start and stop together in IDLE must not launch.
    bus.start = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check_eq("startstop_busy",   32'(bus.busy), 32'd0);
      check_eq("startstop_enable", 32'(bus.dds_enable), 32'd0);
    end
    $display("[TB] start+stop in idle: busy=%0d", bus.busy);
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    for (int n = 0; n < 20; n++) begin
      si   = int'($urandom_range(0, 65535));
      so   = int'($urandom_range(0, 65535));
      diff = (si > so) ? si - so : so - si;
      st   = diff / int'($urandom_range(1, 10)) + int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) st = 0;
      if (st > 65535) st = 65535;
      dw   = int'($urandom_range(0, 3));
      single_sweep(si, so, st, dw);
    end

    // Asynchronous reset between edges, then a clean relaunch.
    launch(16'h0100, 16'h0400, 16'h0100, 3, 1'b0);
    repeat (4) @(posedge clock);
    bus.start = 1'b0;
    #3 reset = 1'b1;
    #1;
    $display("[TB] async reset mid-sweep: inc=0x%0h busy=%0d", bus.dds_phase_inc, bus.busy);
    check_all_zero("async_reset");
    @(negedge clock);
    reset = 1'b0;
    single_sweep(16'h0100, 16'h0400, 16'h0100, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
